imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_pkg.sv | 41 ++++
 rtl/imm_extend_pipe_decode.sv | 78 +++++++
 rtl/imm_extend_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline: select encoding,
// legal parameter values and small helpers used by decode and pipeline.
package imm_extend_pipe_pkg;

    // Immediate format select. Codes 8..15 are reserved and flagged as errors.
    typedef enum logic [3:0] {
        IMM_I     = 4'd0,
        IMM_S     = 4'd1,
        IMM_B     = 4'd2,
        IMM_U     = 4'd3,
        IMM_J     = 4'd4,
        IMM_SHAMT = 4'd5,
        IMM_CSR   = 4'd6,
        IMM_GEMM  = 4'd7
    } imm_sel_e;

    // Legal output widths and pipeline depths.
    localparam int XLEN_RV32  = 32;
    localparam int XLEN_RV64  = 64;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 2;

    // Fixed field widths.
    localparam int INST_W    = 32;
    localparam int SEL_W     = 4;
    localparam int ERR_CNT_W = 16;

    // Saturation ceiling of the illegal-select counter.
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // A select is legal when it names one of the eight defined formats.
    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
        return (sel[SEL_W-1] == 1'b0);
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational immediate decoder: extracts the selected immediate field from
// a raw instruction word and extends it to XLEN bits. Sign-extended formats
// replicate inst[31]; the CSR, shamt and GEMM-offset formats are zero-extended.
module imm_decode
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    input  logic [SEL_W-1:0]  sel,
    output logic [XLEN-1:0]   imm,
    output logic              err
);

    imm_sel_e          sel_e;
    logic signed [31:0] sext32;
    logic [31:0]       zext32;
    logic              use_sext;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    assign sel_e = imm_sel_e'(sel);

    // Build a 32-bit intermediate per format, then widen to XLEN at the end.
    always_comb begin
        sext32   = '0;
        zext32   = '0;
        use_sext = 1'b0;
        err      = 1'b0;
        case (sel_e)
            IMM_I: begin
                use_sext = 1'b1;
                sext32   = {{20{inst[31]}}, inst[31:20]};
            end
            IMM_S: begin
                use_sext = 1'b1;
                sext32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            IMM_B: begin
                use_sext = 1'b1;
                sext32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            end
            IMM_U: begin
                use_sext = 1'b1;
                sext32   = {inst[31:12], 12'b0};
            end
            IMM_J: begin
                use_sext = 1'b1;
                sext32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            end
            IMM_SHAMT: begin
                // RV64 shifts take a 6-bit amount, RV32 a 5-bit one.
                zext32 = (XLEN == XLEN_RV64) ? {26'b0, inst[25:20]}
                                             : {27'b0, inst[24:20]};
            end
            IMM_CSR: begin
                zext32 = {27'b0, inst[19:15]};
            end
            IMM_GEMM: begin
                // Word-granular offset: 12-bit field scaled by 4.
                zext32 = {18'b0, inst[31:20], 2'b00};
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

    // Widening: the signed cast replicates bit 31, the unsigned one pads zeros.
    always_comb begin
        imm = use_sext ? XLEN'(sext32) : XLEN'(zext32);
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension pipeline: decodes the immediate in stage 1 and, when
// STAGES == 2, re-registers the stage-1 result unchanged in stage 2.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready never depends on in_valid, and once
// out_valid rises the result (imm/err/tag_out) holds until it is consumed.
// A stage loads when it is empty or when its current content leaves on the
// same edge, so with out_ready held high one result flows per cycle.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    inst,
    input  logic [SEL_W-1:0]     sel,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm,
    output logic                 err,
    output logic [TAG_W-1:0]     tag_out,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Decoder output feeding stage 1.
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst (inst),
        .sel  (sel),
        .imm  (dec_imm),
        .err  (dec_err)
    );

    // Stage 1 registers.
    logic             s1_valid;
    logic [XLEN-1:0]  s1_imm;
    logic             s1_err;
    logic [TAG_W-1:0] s1_tag;

    // Stage-1 content moves on this cycle (to stage 2 or to the consumer).
    logic s1_adv;
    logic in_fire;

    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Stage 1: capture a decoded result on input transfer, empty when it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_err   <= 1'b0;
            s1_tag   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_imm   <= dec_imm;
            s1_err   <= dec_err;
            s1_tag   <= tag_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    generate
        if (STAGES == STAGES_MAX) begin : g_two_stage
            logic             s2_valid;
            logic [XLEN-1:0]  s2_imm;
            logic             s2_err;
            logic [TAG_W-1:0] s2_tag;
            logic             s2_load;

            // Stage 2 accepts stage 1 when empty or when draining this cycle.
            assign s2_load = s1_valid && (!s2_valid || out_ready);
            assign s1_adv  = s2_load;

            // Stage 2: pure re-register of stage 1, no further processing.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_imm   <= '0;
                    s2_err   <= 1'b0;
                    s2_tag   <= '0;
                end else if (s2_load) begin
                    s2_valid <= 1'b1;
                    s2_imm   <= s1_imm;
                    s2_err   <= s1_err;
                    s2_tag   <= s1_tag;
                end else if (s2_valid && out_ready) begin
                    s2_valid <= 1'b0;
                end
            end

            assign out_valid = s2_valid;
            assign imm       = s2_imm;
            assign err       = s2_err;
            assign tag_out   = s2_tag;
        end else begin : g_one_stage
            assign s1_adv    = s1_valid && out_ready;
            assign out_valid = s1_valid;
            assign imm       = s1_imm;
            assign err       = s1_err;
            assign tag_out   = s1_tag;
        end
    endgenerate

    // Illegal-select counter: clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (in_fire && !sel_is_legal(sel)) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule
